// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants, action encoding and helpers for the generic pipeline stage register.
// Optional PIPE_STAGE_PERF_EN build uses sat_inc32 for its event counters.
package pipe_stage_reg_pkg;

  localparam logic        STOP              = 1'b1;
  localparam logic        NO_STOP           = 1'b0;
  localparam logic        RST_ENABLE        = 1'b0;
  localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR      = 5'b00000;
  localparam logic        NOT_IN_DELAY_SLOT = 1'b0;
  localparam logic        IN_DELAY_SLOT     = 1'b1;

  // One-hot so a single bit identifies the edge action in every stage instance.
  typedef enum logic [4:0] {
    ACT_RESET   = 5'b00001,
    ACT_FLUSH   = 5'b00010,
    ACT_BUBBLE  = 5'b00100,
    ACT_ADVANCE = 5'b01000,
    ACT_HOLD    = 5'b10000
  } pipe_act_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/pipe_stall_ctl.sv
// Decodes reset, flush and the global stall vector into this stage's one-hot edge action.
module pipe_stall_ctl
  import pipe_stage_reg_pkg::*;
#(
  parameter int STALL_W = 6,
  parameter int STAGE   = 2
) (
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  output pipe_act_e          act
);

  logic own_s;
  logic down_s;
  logic unused_stall_s;

  assign unused_stall_s = ^stall;

  // The last stage has no downstream stall bit, so it never sees a downstream stop.
  generate
    if (STAGE >= STALL_W) begin : g_bad_stage
      $error("pipe_stall_ctl: STAGE must be below STALL_W");
      assign own_s  = NO_STOP;
      assign down_s = NO_STOP;
    end else if (STAGE == STALL_W - 1) begin : g_last_stage
      assign own_s  = stall[STAGE];
      assign down_s = NO_STOP;
    end else begin : g_mid_stage
      assign own_s  = stall[STAGE];
      assign down_s = stall[STAGE+1];
    end
  endgenerate

  // Priority decode: reset, flush, advance, bubble, hold.
  always_comb begin
    act = ACT_HOLD;
    if (rst == RST_ENABLE) begin
      act = ACT_RESET;
    end else if (flush == 1'b1) begin
      act = ACT_FLUSH;
    end else if (own_s == NO_STOP) begin
      act = ACT_ADVANCE;
    end else if (down_s == NO_STOP) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_HOLD;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid, flush, bubble insertion and delay-slot tracking.
// Define PIPE_STAGE_PERF_EN to add saturating bubble_cnt / hold_cnt event counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                   PAYLOAD_W   = 77,
  parameter int                   REG_ADDR_W  = 5,
  parameter int                   STALL_W     = 6,
  parameter int                   STAGE       = 2,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = {PAYLOAD_W{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] in_wd,
  input  logic                  in_wreg,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  input  logic                  in_is_in_delayslot,
  input  logic                  next_inst_in_delayslot_i,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]           bubble_cnt,
  output logic [31:0]           hold_cnt,
`endif
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] out_wd,
  output logic                  out_wreg,
  output logic [PAYLOAD_W-1:0]  out_payload,
  output logic                  out_is_in_delayslot,
  output logic                  is_in_delayslot_o
);

  localparam logic [REG_ADDR_W-1:0] WD_NOP = REG_ADDR_W'(NOP_REG_ADDR);

  pipe_act_e act_s;

  logic                  valid_r,   valid_s;
  logic [REG_ADDR_W-1:0] wd_r,      wd_s;
  logic                  wreg_r,    wreg_s;
  logic [PAYLOAD_W-1:0]  payload_r, payload_s;
  logic                  ids_r,     ids_s;
  logic                  ds_trk_r,  ds_trk_s;

  pipe_stall_ctl #(
    .STALL_W (STALL_W),
    .STAGE   (STAGE)
  ) u_stall_ctl (
    .rst   (rst),
    .flush (flush),
    .stall (stall),
    .act   (act_s)
  );

  // Next-state selection; the delay-slot tracker only moves on ADVANCE so it survives stalls.
  always_comb begin
    valid_s   = valid_r;
    wd_s      = wd_r;
    wreg_s    = wreg_r;
    payload_s = payload_r;
    ids_s     = ids_r;
    ds_trk_s  = ds_trk_r;
    case (act_s)
      ACT_BUBBLE: begin
        valid_s   = 1'b0;
        wd_s      = WD_NOP;
        wreg_s    = 1'b0;
        payload_s = NOP_PAYLOAD;
        ids_s     = NOT_IN_DELAY_SLOT;
      end
      ACT_ADVANCE: begin
        if (in_valid == 1'b1) begin
          valid_s   = 1'b1;
          wd_s      = in_wd;
          wreg_s    = in_wreg;
          payload_s = in_payload;
          ids_s     = in_is_in_delayslot;
        end else begin
          valid_s   = 1'b0;
          wd_s      = WD_NOP;
          wreg_s    = 1'b0;
          payload_s = NOP_PAYLOAD;
          ids_s     = NOT_IN_DELAY_SLOT;
        end
        ds_trk_s = next_inst_in_delayslot_i;
      end
      ACT_HOLD: begin
        ds_trk_s = ds_trk_r;
      end
      default: begin
        valid_s   = 1'b0;
        wd_s      = WD_NOP;
        wreg_s    = 1'b0;
        payload_s = NOP_PAYLOAD;
        ids_s     = NOT_IN_DELAY_SLOT;
        ds_trk_s  = NOT_IN_DELAY_SLOT;
      end
    endcase
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      valid_r   <= 1'b0;
      wd_r      <= WD_NOP;
      wreg_r    <= 1'b0;
      payload_r <= NOP_PAYLOAD;
      ids_r     <= NOT_IN_DELAY_SLOT;
      ds_trk_r  <= NOT_IN_DELAY_SLOT;
    end else begin
      valid_r   <= valid_s;
      wd_r      <= wd_s;
      wreg_r    <= wreg_s;
      payload_r <= payload_s;
      ids_r     <= ids_s;
      ds_trk_r  <= ds_trk_s;
    end
  end

  assign out_valid           = valid_r;
  assign out_wd              = wd_r;
  assign out_wreg            = wreg_r;
  assign out_payload         = payload_r;
  assign out_is_in_delayslot = ids_r;
  assign is_in_delayslot_o   = ds_trk_r;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] bubble_cnt_r, bubble_cnt_s;
  logic [31:0] hold_cnt_r,   hold_cnt_s;

  // Event counters: an empty slot entering the stage counts as a bubble.
  always_comb begin
    bubble_cnt_s = bubble_cnt_r;
    hold_cnt_s   = hold_cnt_r;
    case (act_s)
      ACT_BUBBLE: begin
        bubble_cnt_s = sat_inc32(bubble_cnt_r);
      end
      ACT_ADVANCE: begin
        if (in_valid == 1'b0) begin
          bubble_cnt_s = sat_inc32(bubble_cnt_r);
        end else begin
          bubble_cnt_s = bubble_cnt_r;
        end
      end
      ACT_HOLD: begin
        hold_cnt_s = sat_inc32(hold_cnt_r);
      end
      default: begin
        bubble_cnt_s = ZERO_WORD;
        hold_cnt_s   = ZERO_WORD;
      end
    endcase
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      bubble_cnt_r <= ZERO_WORD;
      hold_cnt_r   <= ZERO_WORD;
    end else begin
      bubble_cnt_r <= bubble_cnt_s;
      hold_cnt_r   <= hold_cnt_s;
    end
  end

  assign bubble_cnt = bubble_cnt_r;
  assign hold_cnt   = hold_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: a mid-pipe instance (STAGE=2) and a last-stage one (STAGE=5).
module tb_pipe_stage_reg;

  localparam int PW = 77;
  localparam logic [PW-1:0] NOP_A = 77'h0_0000_0000_00AB_CDEF;
  localparam logic [PW-1:0] P1    = 77'h1_2345_6789_ABCD_EF01;
  localparam logic [PW-1:0] P2    = 77'h0_F0F0_1111_2222_3333;
  localparam logic [PW-1:0] P3    = 77'h1_5555_AAAA_5555_AAAA;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  logic          flush;
  logic          in_valid;
  logic [4:0]    in_wd;
  logic          in_wreg;
  logic [PW-1:0] in_payload;
  logic          in_ids;
  logic          next_ds;

  logic          a_valid, a_wreg, a_ids, a_ds;
  logic [4:0]    a_wd;
  logic [PW-1:0] a_payload;
  logic          b_valid, b_wreg, b_ids, b_ds;
  logic [4:0]    b_wd;
  logic [PW-1:0] b_payload;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   a_bcnt, a_hcnt, b_bcnt, b_hcnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.STAGE(2), .NOP_PAYLOAD(NOP_A)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_wd(in_wd), .in_wreg(in_wreg), .in_payload(in_payload),
    .in_is_in_delayslot(in_ids), .next_inst_in_delayslot_i(next_ds),
`ifdef PIPE_STAGE_PERF_EN
    .bubble_cnt(a_bcnt), .hold_cnt(a_hcnt),
`endif
    .out_valid(a_valid), .out_wd(a_wd), .out_wreg(a_wreg), .out_payload(a_payload),
    .out_is_in_delayslot(a_ids), .is_in_delayslot_o(a_ds)
  );

  pipe_stage_reg #(.STAGE(5)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_wd(in_wd), .in_wreg(in_wreg), .in_payload(in_payload),
    .in_is_in_delayslot(in_ids), .next_inst_in_delayslot_i(next_ds),
`ifdef PIPE_STAGE_PERF_EN
    .bubble_cnt(b_bcnt), .hold_cnt(b_hcnt),
`endif
    .out_valid(b_valid), .out_wd(b_wd), .out_wreg(b_wreg), .out_payload(b_payload),
    .out_is_in_delayslot(b_ids), .is_in_delayslot_o(b_ds)
  );

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [4:0] wd, input logic wr,
                       input logic [PW-1:0] p, input logic ids, input logic ds);
    chk_eq({tag, ".valid"}, 128'(a_valid), 128'(v));
    chk_eq({tag, ".wd"}, 128'(a_wd), 128'(wd));
    chk_eq({tag, ".wreg"}, 128'(a_wreg), 128'(wr));
    chk_eq({tag, ".payload"}, 128'(a_payload), 128'(p));
    chk_eq({tag, ".ids"}, 128'(a_ids), 128'(ids));
    chk_eq({tag, ".ds"}, 128'(a_ds), 128'(ds));
  endtask

  task automatic drive(input logic v, input logic [4:0] wd, input logic wr,
                       input logic [PW-1:0] p, input logic ids, input logic nds);
    in_valid = v; in_wd = wd; in_wreg = wr; in_payload = p; in_ids = ids; next_ds = nds;
  endtask

  initial begin
    rst = 1'b0; stall = 6'b000000; flush = 1'b0;
    drive(1'b1, 5'd7, 1'b1, P1, 1'b1, 1'b1);
    #1;
    step(); step();
    chk_a("reset", 1'b0, 5'd0, 1'b0, NOP_A, 1'b0, 1'b0);
    chk_eq("reset_b.payload", 128'(b_payload), 128'(0));
    chk_eq("reset_b.valid", 128'(b_valid), 128'(0));

    // First advance after reset.
    rst = 1'b1;
    drive(1'b1, 5'd7, 1'b1, P1, 1'b0, 1'b0);
    step();
    chk_a("adv1", 1'b1, 5'd7, 1'b1, P1, 1'b0, 1'b0);

    // Own stall, downstream running: bubble, tracker holds 0.
    stall = 6'b000100;
    drive(1'b1, 5'd9, 1'b1, P2, 1'b1, 1'b1);
    step();
    chk_a("bubble", 1'b0, 5'd0, 1'b0, NOP_A, 1'b0, 1'b0);
    chk_eq("bubble_b.ds", 128'(b_ds), 128'(1));
    stall = 6'b000000;
    step();
    chk_a("adv2", 1'b1, 5'd9, 1'b1, P2, 1'b1, 1'b1);

    // Hold for three edges while inputs change.
    stall = 6'b001100;
    drive(1'b0, 5'd3, 1'b0, P3, 1'b0, 1'b0);
    step();
    chk_a("hold1", 1'b1, 5'd9, 1'b1, P2, 1'b1, 1'b1);
    drive(1'b1, 5'd4, 1'b1, P1, 1'b0, 1'b0);
    step(); step();
    chk_a("hold3", 1'b1, 5'd9, 1'b1, P2, 1'b1, 1'b1);

    // Flush beats the stall and clears the tracker.
    flush = 1'b1;
    step();
    chk_a("flush", 1'b0, 5'd0, 1'b0, NOP_A, 1'b0, 1'b0);
    flush = 1'b0;

    // Advance with an empty slot: bubble fields, tracker still follows upstream.
    stall = 6'b000000;
    drive(1'b0, 5'd4, 1'b1, P3, 1'b1, 1'b1);
    step();
    chk_a("adv_inv", 1'b0, 5'd0, 1'b0, NOP_A, 1'b0, 1'b1);
    stall = 6'b000100;
    drive(1'b1, 5'd5, 1'b1, P1, 1'b1, 1'b0);
    step();
    chk_a("bubble_hold_ds", 1'b0, 5'd0, 1'b0, NOP_A, 1'b0, 1'b1);

    // Last stage: own stop with no downstream bit gives a bubble.
    stall = 6'b000000;
    drive(1'b1, 5'd12, 1'b1, P3, 1'b0, 1'b0);
    step();
    chk_eq("last_adv.valid", 128'(b_valid), 128'(1));
    chk_eq("last_adv.wd", 128'(b_wd), 128'(12));
    chk_eq("last_adv.payload", 128'(b_payload), 128'(P3));
    stall = 6'b100000;
    drive(1'b1, 5'd13, 1'b1, P1, 1'b0, 1'b0);
    step();
    chk_eq("last_bubble.valid", 128'(b_valid), 128'(0));
    chk_eq("last_bubble.wreg", 128'(b_wreg), 128'(0));
    chk_eq("last_bubble.wd", 128'(b_wd), 128'(0));
    chk_a("a_during_last", 1'b1, 5'd13, 1'b1, P1, 1'b0, 1'b0);

    // Reset while holding and flushing.
    stall = 6'b001100; flush = 1'b1; rst = 1'b0;
    step();
    chk_a("rst_mid", 1'b0, 5'd0, 1'b0, NOP_A, 1'b0, 1'b0);
    rst = 1'b1; flush = 1'b0; stall = 6'b000000;
    drive(1'b1, 5'd1, 1'b0, P2, 1'b0, 1'b0);
    step();
    chk_a("adv_wreg0", 1'b1, 5'd1, 1'b0, P2, 1'b0, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    flush = 1'b1;
    step();
    flush = 1'b0;
    stall = 6'b000100;
    for (int i = 0; i < 4; i++) step();
    stall = 6'b001100;
    for (int i = 0; i < 2; i++) step();
    chk_eq("perf.bubble", 128'(a_bcnt), 128'(4));
    chk_eq("perf.hold", 128'(a_hcnt), 128'(2));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_eq("perf.flush_b", 128'(a_bcnt), 128'(0));
    chk_eq("perf.flush_h", 128'(a_hcnt), 128'(0));
    force dut_a.bubble_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut_a.bubble_cnt_r;
    stall = 6'b000100;
    step();
    chk_eq("perf.sat", 128'(a_bcnt), 128'(32'hFFFF_FFFF));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
